// File: rtl/pcm_voice_engine.sv
// Multi-channel PCM voice engine: walks every voice once per frame,
// fetches ROM bytes, decodes 8/16-bit or 4-bit DPCM and emits samples.
module pcm_voice_engine #(
    parameter int CHANNELS = 8,
    parameter int ADDR_W   = 24,
    parameter int PITCH_W  = 24
) (
    input  logic              CLK,
    input  logic              NRES,
    input  logic              wr_en,
    input  logic [9:0]        wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              frame_start,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data,
    output logic              smp_valid,
    output logic [2:0]        smp_ch,
    output logic [15:0]       smp_data,
    output logic              frame_done,
    output logic              frame_ovr
);

    typedef enum logic [2:0] {
        IDLE, LOAD, FETCH_LO, FETCH_HI, DECODE, EMIT, ADVANCE
    } state_e;

    state_e state_q, state_d;

    logic [PITCH_W-1:0] pitch_q [CHANNELS];
    logic [ADDR_W-1:0]  start_q [CHANNELS];
    logic [ADDR_W-1:0]  loop_q  [CHANNELS];
    logic [2:0]         mode_q  [CHANNELS];
    logic [CHANNELS-1:0] pend_on_q, pend_off_q;

    logic [ADDR_W:0]     pos_q  [CHANNELS];
    logic [ADDR_W:0]     lpos_q [CHANNELS];
    logic [15:0]         frac_q [CHANNELS];
    logic signed [15:0]  acc_q  [CHANNELS];
    logic [CHANNELS-1:0] active_q, first_q;

    logic [2:0]        ch_q;
    logic [7:0]        lo_q, hi_q;
    logic [15:0]       smp_q;
    logic              looped_q;
    logic              rom_req_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              frame_done_q, frame_ovr_q;

    function automatic logic [23:0] put_byte(
        input logic [23:0] old,
        input logic [1:0]  idx,
        input logic [7:0]  d
    );
        logic [23:0] r;
        r = old;
        case (idx)
            2'd0:    r[7:0]   = d;
            2'd1:    r[15:8]  = d;
            2'd2:    r[23:16] = d;
            default: r = old;
        endcase
        return r;
    endfunction

    function automatic logic signed [7:0] dpcm_delta(input logic [3:0] n);
        logic signed [7:0] r;
        case (n)
            4'd0:    r = 8'sd0;
            4'd1:    r = 8'sd1;
            4'd2:    r = 8'sd4;
            4'd3:    r = 8'sd9;
            4'd4:    r = 8'sd16;
            4'd5:    r = 8'sd25;
            4'd6:    r = 8'sd36;
            4'd7:    r = 8'sd49;
            4'd8:    r = -8'sd64;
            4'd9:    r = -8'sd49;
            4'd10:   r = -8'sd36;
            4'd11:   r = -8'sd25;
            4'd12:   r = -8'sd16;
            4'd13:   r = -8'sd9;
            4'd14:   r = -8'sd4;
            default: r = -8'sd1;
        endcase
        return r;
    endfunction

    logic       wr_ch_ok, key_on_wr, key_off_wr, accept;
    logic [2:0] wr_ch;
    logic [1:0] wr_idx, wr_fld;

    logic [ADDR_W:0]    cur_pos;
    logic signed [15:0] cur_acc;
    logic               is16, isdp, loop_en, marker, dp_apply, last_ch;
    logic [ADDR_W-1:0]  addr_lo;
    logic [3:0]         nib;
    logic signed [17:0] acc_sum;
    logic signed [15:0] acc_sat;
    logic [ADDR_W+16:0] adv_sum;

    // Decode CPU write address and current-channel datapath values.
    always_comb begin
        wr_ch      = wr_addr[6:4];
        wr_fld     = wr_addr[3:2];
        wr_idx     = wr_addr[1:0];
        wr_ch_ok   = wr_en && (wr_addr[9:7] == 3'd0)
                     && ({29'd0, wr_ch} < 32'(CHANNELS));
        key_on_wr  = wr_en && (wr_addr == 10'h200);
        key_off_wr = wr_en && (wr_addr == 10'h201);
        accept     = (state_q == IDLE) && frame_start;

        cur_pos  = pos_q[ch_q];
        cur_acc  = acc_q[ch_q];
        is16     = (mode_q[ch_q][1:0] == 2'b01);
        isdp     = (mode_q[ch_q][1:0] == 2'b10);
        loop_en  = mode_q[ch_q][2];
        last_ch  = (ch_q == 3'(CHANNELS - 1));

        if (is16) begin
            addr_lo = start_q[ch_q] + ADDR_W'({cur_pos, 1'b0});
        end else if (isdp) begin
            addr_lo = start_q[ch_q] + ADDR_W'(cur_pos >> 1);
        end else begin
            addr_lo = start_q[ch_q] + ADDR_W'(cur_pos);
        end

        if (is16) begin
            marker = ({hi_q, lo_q} == 16'h8000);
        end else if (isdp) begin
            marker = (lo_q == 8'h88);
        end else begin
            marker = (lo_q == 8'h80);
        end

        nib      = cur_pos[0] ? lo_q[7:4] : lo_q[3:0];
        dp_apply = first_q[ch_q] || (cur_pos != lpos_q[ch_q]);
        acc_sum  = 18'(cur_acc) + (18'(dpcm_delta(nib)) <<< 8);
        if (acc_sum > 18'sd32767) begin
            acc_sat = 16'sh7fff;
        end else if (acc_sum < -18'sd32768) begin
            acc_sat = 16'sh8000;
        end else begin
            acc_sat = acc_sum[15:0];
        end

        adv_sum = {cur_pos, frac_q[ch_q]}
                  + (ADDR_W + 17)'(pitch_q[ch_q]);
    end

    // CPU register file and pending key-on/off bits.
    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            for (int c = 0; c < CHANNELS; c++) begin
                pitch_q[c] <= '0;
                start_q[c] <= '0;
                loop_q[c]  <= '0;
                mode_q[c]  <= '0;
            end
            pend_on_q  <= '0;
            pend_off_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_ch_ok && (wr_ch == 3'(c))) begin
                    case (wr_fld)
                        2'd0: pitch_q[c] <= PITCH_W'(put_byte(
                                  24'(pitch_q[c]), wr_idx, wr_data));
                        2'd1: start_q[c] <= ADDR_W'(put_byte(
                                  24'(start_q[c]), wr_idx, wr_data));
                        2'd2: loop_q[c]  <= ADDR_W'(put_byte(
                                  24'(loop_q[c]), wr_idx, wr_data));
                        default: begin
                            if (wr_idx == 2'd0) mode_q[c] <= wr_data[2:0];
                        end
                    endcase
                end
            end
            pend_on_q  <= (accept ? '0 : pend_on_q)
                          | (key_on_wr ? wr_data[CHANNELS-1:0] : '0);
            pend_off_q <= (accept ? '0 : pend_off_q)
                          | (key_off_wr ? wr_data[CHANNELS-1:0] : '0);
        end
    end

    // Sequencer state register.
    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (frame_start) state_d = LOAD;
            LOAD:     state_d = active_q[ch_q] ? FETCH_LO : EMIT;
            FETCH_LO: if (rom_req_q && rom_ack) state_d = is16 ? FETCH_HI : DECODE;
            FETCH_HI: if (rom_req_q && rom_ack) state_d = DECODE;
            DECODE:   state_d = (marker && loop_en && !looped_q) ? FETCH_LO : EMIT;
            EMIT:     state_d = ADVANCE;
            ADVANCE:  state_d = last_ch ? IDLE : LOAD;
            default:  state_d = IDLE;
        endcase
    end

    // Channel state, ROM handshake and sample formation.
    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            for (int c = 0; c < CHANNELS; c++) begin
                pos_q[c]  <= '0;
                lpos_q[c] <= '0;
                frac_q[c] <= '0;
                acc_q[c]  <= '0;
            end
            active_q     <= '0;
            first_q      <= '0;
            ch_q         <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            smp_q        <= '0;
            looped_q     <= 1'b0;
            rom_req_q    <= 1'b0;
            rom_addr_q   <= '0;
            frame_done_q <= 1'b0;
            frame_ovr_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            frame_ovr_q  <= frame_start && (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        ch_q <= '0;
                        for (int c = 0; c < CHANNELS; c++) begin
                            if (pend_off_q[c]) begin
                                active_q[c] <= 1'b0;
                            end else if (pend_on_q[c]) begin
                                active_q[c] <= 1'b1;
                                first_q[c]  <= 1'b1;
                                pos_q[c]    <= '0;
                                frac_q[c]   <= '0;
                                acc_q[c]    <= '0;
                            end
                        end
                    end
                end
                LOAD: begin
                    looped_q <= 1'b0;
                    if (!active_q[ch_q]) smp_q <= '0;
                end
                FETCH_LO: begin
                    if (!rom_req_q) begin
                        rom_addr_q <= addr_lo;
                        rom_req_q  <= 1'b1;
                    end else if (rom_ack) begin
                        lo_q      <= rom_data;
                        rom_req_q <= 1'b0;
                    end
                end
                FETCH_HI: begin
                    if (!rom_req_q) begin
                        rom_addr_q <= addr_lo + ADDR_W'(1);
                        rom_req_q  <= 1'b1;
                    end else if (rom_ack) begin
                        hi_q      <= rom_data;
                        rom_req_q <= 1'b0;
                    end
                end
                DECODE: begin
                    if (marker) begin
                        if (loop_en && !looped_q) begin
                            pos_q[ch_q] <= {1'b0, loop_q[ch_q]};
                            looped_q    <= 1'b1;
                        end else begin
                            active_q[ch_q] <= 1'b0;
                            smp_q          <= '0;
                        end
                    end else if (is16) begin
                        smp_q <= {hi_q, lo_q};
                    end else if (isdp) begin
                        lpos_q[ch_q] <= cur_pos;
                        if (dp_apply) begin
                            acc_q[ch_q] <= acc_sat;
                            smp_q       <= acc_sat;
                        end else begin
                            smp_q <= cur_acc;
                        end
                    end else begin
                        smp_q <= {lo_q, 8'h00};
                    end
                end
                ADVANCE: begin
                    if (active_q[ch_q]) begin
                        {pos_q[ch_q], frac_q[ch_q]} <= adv_sum;
                        first_q[ch_q] <= 1'b0;
                    end
                    if (last_ch) frame_done_q <= 1'b1;
                    else         ch_q <= ch_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign rom_req    = rom_req_q;
    assign rom_addr   = rom_addr_q;
    assign smp_valid  = (state_q == EMIT);
    assign smp_ch     = (state_q == EMIT) ? ch_q : 3'd0;
    assign smp_data   = (state_q == EMIT) ? smp_q : 16'd0;
    assign frame_done = frame_done_q;
    assign frame_ovr  = frame_ovr_q;

endmodule

// File: tb/tb_pcm_voice_engine.sv
// Scoreboard bench for pcm_voice_engine: directed frames, expected
// samples queued per frame and popped by an output monitor.
module tb_pcm_voice_engine;

    logic        CLK = 1'b0;
    logic        NRES = 1'b0;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        frame_start = 1'b0;
    logic        rom_req;
    logic [23:0] rom_addr;
    logic        rom_ack;
    logic [7:0]  rom_data;
    logic        smp_valid;
    logic [2:0]  smp_ch;
    logic [15:0] smp_data;
    logic        frame_done;
    logic        frame_ovr;

    logic        hold_ack = 1'b0;
    logic [7:0]  mem [0:4095];

    int checks = 0;
    int failures = 0;
    int n_done = 0;
    int n_ovr = 0;
    int n_req = 0;

    logic [18:0] sb_q [$];
    logic [23:0] ack_log [$];
    logic [15:0] ev [8];
    logic [18:0] exp_e;

    pcm_voice_engine dut (
        .CLK(CLK), .NRES(NRES),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_start(frame_start),
        .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_ack(rom_ack), .rom_data(rom_data),
        .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_data(smp_data),
        .frame_done(frame_done), .frame_ovr(frame_ovr)
    );

    always #5 CLK = ~CLK;

    assign rom_ack  = rom_req & ~hold_ack;
    assign rom_data = mem[rom_addr[11:0]];

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Output monitor: pops the scoreboard on every sample strobe.
    always @(negedge CLK) begin
        if (frame_done) n_done++;
        if (frame_ovr) n_ovr++;
        if (rom_req) n_req++;
        if (rom_req && rom_ack) ack_log.push_back(rom_addr);
        if (smp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sample_unexpected got ch=%0d data=%h required none",
                         smp_ch, smp_data);
            end else begin
                exp_e = sb_q.pop_front();
                if ({smp_ch, smp_data} !== exp_e) begin
                    failures++;
                    $display("FAIL sample got ch=%0d data=%h required ch=%0d data=%h",
                             smp_ch, smp_data, exp_e[18:16], exp_e[15:0]);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", nm, got, req);
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [7:0] d);
        @(negedge CLK);
        wr_en = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    task automatic cfg(input int ch, input logic [23:0] pitch,
                       input logic [23:0] start, input logic [23:0] lp,
                       input logic [7:0] mode);
        logic [9:0] b;
        b = 10'(ch * 16);
        wr(b + 10'd0, pitch[7:0]);
        wr(b + 10'd1, pitch[15:8]);
        wr(b + 10'd2, pitch[23:16]);
        wr(b + 10'd4, start[7:0]);
        wr(b + 10'd5, start[15:8]);
        wr(b + 10'd6, start[23:16]);
        wr(b + 10'd8, lp[7:0]);
        wr(b + 10'd9, lp[15:8]);
        wr(b + 10'd10, lp[23:16]);
        wr(b + 10'd12, mode);
    endtask

    task automatic zero_ev;
        for (int i = 0; i < 8; i++) ev[i] = 16'h0000;
    endtask

    task automatic push_ev;
        for (int i = 0; i < 8; i++) sb_q.push_back({3'(i), ev[i]});
    endtask

    task automatic run_frame(output int cyc);
        push_ev();
        @(negedge CLK);
        frame_start = 1'b1;
        @(negedge CLK);
        frame_start = 1'b0;
        cyc = 1;
        while (!frame_done && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
        end
        check("frame_done_seen", 32'(frame_done), 32'd1);
        check("frame_drained", sb_q.size(), 32'd0);
    endtask

    int          cyc, r0, d0, o0, base, k;
    logic [23:0] a;
    logic        stable;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h12;
        mem[12'h101] = 8'h34;
        mem[12'h102] = 8'h80;
        mem[12'h200] = 8'h11;
        mem[12'h201] = 8'h11;
        mem[12'h202] = 8'h22;
        mem[12'h203] = 8'h22;
        mem[12'h204] = 8'h00;
        mem[12'h205] = 8'h80;
        for (int i = 0; i < 8; i++) mem[12'h300 + i] = 8'h77;
        mem[12'h400] = 8'h55;

        // reset state
        repeat (3) @(negedge CLK);
        check("reset_ctrl", 32'({rom_req, smp_valid, frame_done,
                                 frame_ovr, smp_ch}), 32'd0);
        check("reset_data", 32'(smp_data), 32'd0);
        check("reset_addr", 32'(rom_addr), 32'd0);
        @(negedge CLK);
        NRES = 1'b1;
        repeat (2) @(negedge CLK);

        // idle frame
        zero_ev();
        r0 = n_req;
        run_frame(cyc);
        check("idle_frame_cycles", cyc, 32'd25);
        check("idle_no_rom_req", n_req - r0, 32'd0);

        // 8-bit playback on ch0
        cfg(0, 24'h010000, 24'h000100, 24'h0, 8'h00);
        wr(10'h200, 8'h01);
        zero_ev();
        ev[0] = 16'h1200;
        run_frame(cyc);
        check("8bit_frame_cycles", cyc, 32'd28);
        ev[0] = 16'h3400;
        run_frame(cyc);
        ev[0] = 16'h0000;
        run_frame(cyc);
        r0 = n_req;
        run_frame(cyc);
        check("8bit_inactive_no_fetch", n_req - r0, 32'd0);

        // 16-bit loop on ch1
        cfg(1, 24'h010000, 24'h000200, 24'h000001, 8'h05);
        wr(10'h200, 8'h02);
        zero_ev();
        ev[1] = 16'h1111;
        run_frame(cyc);
        ev[1] = 16'h2222;
        run_frame(cyc);
        base = ack_log.size();
        run_frame(cyc);
        check("loop_fetch_count", ack_log.size() - base, 32'd4);
        a = (ack_log.size() > base + 2) ? ack_log[base + 2] : 24'hffffff;
        check("loop_refetch_addr", 32'(a), 32'h202);
        run_frame(cyc);

        // DPCM saturation on ch2, ch1 keyed off
        cfg(2, 24'h010000, 24'h000300, 24'h0, 8'h02);
        wr(10'h201, 8'h02);
        wr(10'h200, 8'h04);
        zero_ev();
        ev[2] = 16'h3100;
        run_frame(cyc);
        ev[2] = 16'h6200;
        run_frame(cyc);
        ev[2] = 16'h7fff;
        run_frame(cyc);
        run_frame(cyc);

        // DPCM half-rate pitch: repeats without re-applying delta
        wr(10'h020, 8'h00);
        wr(10'h021, 8'h80);
        wr(10'h022, 8'h00);
        wr(10'h200, 8'h04);
        ev[2] = 16'h3100;
        run_frame(cyc);
        run_frame(cyc);
        ev[2] = 16'h6200;
        run_frame(cyc);
        run_frame(cyc);
        ev[2] = 16'h7fff;
        run_frame(cyc);

        // ROM stall and ignored frame_start
        cfg(3, 24'h010000, 24'h000400, 24'h0, 8'h00);
        wr(10'h201, 8'h04);
        wr(10'h200, 8'h08);
        zero_ev();
        ev[3] = 16'h5500;
        push_ev();
        d0 = n_done;
        o0 = n_ovr;
        hold_ack = 1'b1;
        @(negedge CLK);
        frame_start = 1'b1;
        @(negedge CLK);
        frame_start = 1'b0;
        k = 0;
        while (!rom_req && k < 100) begin
            @(negedge CLK);
            k++;
        end
        check("stall_req_seen", 32'(rom_req), 32'd1);
        a = rom_addr;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            frame_start = (i == 1);
            if (!rom_req || rom_addr !== a) stable = 1'b0;
        end
        frame_start = 1'b0;
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_addr", 32'(a), 32'h400);
        hold_ack = 1'b0;
        k = 0;
        while (!frame_done && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check("stall_frame_done", 32'(frame_done), 32'd1);
        repeat (40) @(negedge CLK);
        check("ovr_pulses", n_ovr - o0, 32'd1);
        check("single_pass", n_done - d0, 32'd1);
        check("stall_drained", sb_q.size(), 32'd0);

        // key-on/key-off collision: off wins
        wr(10'h200, 8'h01);
        wr(10'h201, 8'h09);
        zero_ev();
        r0 = n_req;
        run_frame(cyc);
        check("collision_no_fetch", n_req - r0, 32'd0);

        // asynchronous reset during FETCH_LO
        wr(10'h200, 8'h01);
        hold_ack = 1'b1;
        d0 = n_done;
        @(negedge CLK);
        frame_start = 1'b1;
        @(negedge CLK);
        frame_start = 1'b0;
        k = 0;
        while (!rom_req && k < 100) begin
            @(negedge CLK);
            k++;
        end
        check("rst_req_seen", 32'(rom_req), 32'd1);
        #2;
        NRES = 1'b0;
        #1;
        check("rst_async_ctrl", 32'({rom_req, smp_valid, frame_done,
                                     frame_ovr, smp_ch}), 32'd0);
        check("rst_async_data", 32'(smp_data), 32'd0);
        check("rst_async_addr", 32'(rom_addr), 32'd0);
        @(negedge CLK);
        hold_ack = 1'b0;
        repeat (3) @(negedge CLK);
        NRES = 1'b1;
        repeat (30) @(negedge CLK);
        check("rst_no_done", n_done - d0, 32'd0);
        zero_ev();
        r0 = n_req;
        run_frame(cyc);
        check("post_reset_cycles", cyc, 32'd25);
        check("post_reset_no_fetch", n_req - r0, 32'd0);

        repeat (5) @(negedge CLK);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
